// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register/opcode widths, opcodes, jump encodings, MEM-stage FSM states.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t J   = 6'h02;
  localparam opcode_t JAL = 6'h03;
  localparam opcode_t BEQ = 6'h04;
  localparam opcode_t BNE = 6'h05;
  localparam opcode_t LW  = 6'h23;
  localparam opcode_t SW  = 6'h2B;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} mem_state_t;

  // PC-relative branch target; wraps modulo 2^32
  function automatic word_t branch_target(input word_t cpc, input word_t imm);
    return cpc + (imm << 2);
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/response bundle between the MEM stage (master) and the cache (slave).
interface mem_stage_if;
  import cpu_types_pkg::*;
  logic  dmemREN, dmemWEN;
  word_t dmemaddr, dmemstore;
  word_t dmemload;
  logic  dhit;

  modport master(output dmemREN, dmemWEN, dmemaddr, dmemstore, input dmemload, dhit);
  modport slave (input dmemREN, dmemWEN, dmemaddr, dmemstore, output dmemload, dhit);
endinterface

// File: rtl/mem_stage_branch.sv
// Branch/jump resolution for the MEM stage: decides taken and computes the redirect target.
module mem_branch_resolve
  import cpu_types_pkg::*;
(
  input  logic        branch,
  input  logic        zflag,
  input  opcode_t     opcode,
  input  logic [1:0]  jump,
  input  word_t       cpc,
  input  word_t       imm,
  input  word_t       regtarget,
  input  logic [25:0] jaddr,
  output logic        taken,
  output word_t       target
);
  always_comb begin
    taken  = 1'b0;
    target = '0;
    if (branch && ((opcode == BEQ && zflag) || (opcode == BNE && !zflag))) begin
      taken  = 1'b1;
      target = branch_target(cpc, imm);
    end else if (jump == JMP_J) begin
      taken  = 1'b1;
      target = {cpc[31:28], jaddr, 2'b00};
    end else if (jump == JMP_JR) begin
      taken  = 1'b1;
      target = regtarget;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-cache handshake FSM, branch/jump redirect and the MEM/WB register.
// Optional MEM_FWD_EN adds MEM/WB forwarding outputs for the hazard unit.
module mem_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_valid,
  input  word_t       ex_cpc, ex_aluout, ex_writeData, ex_imm, ex_regtarget,
  input  logic        ex_regWrite, ex_memtoReg, ex_halt, ex_branch, ex_zflag, ex_dren, ex_dwen,
  input  logic [1:0]  ex_jump,
  input  regbits_t    ex_wsel,
  input  logic [25:0] ex_jaddr,
  input  opcode_t     ex_opcode,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic        pc_redirect,
  output word_t       pc_target,
  output logic        wb_valid, wb_regWrite, wb_memtoReg, wb_halt,
  output regbits_t    wb_wsel,
  output word_t       wb_aluout, wb_dload, wb_cpc
`ifdef MEM_FWD_EN
  ,
  output logic        fwd_en,
  output regbits_t    fwd_wsel,
  output word_t       fwd_data
`endif
);
  mem_state_t state;
  logic  mem_op, ld_wb, retire, br_taken;
  word_t br_target;

  assign mem_op = ex_valid && (ex_dren || ex_dwen);

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = mem_op;
      ACCESS:  mem_stall = !dmem.dhit;
      default: mem_stall = 1'b0;
    endcase
  end

  // MEM/WB captures the instruction only when it completes here; otherwise a bubble
  assign ld_wb  = (state == IDLE && ex_valid && !mem_op) || (state == ACCESS && dmem.dhit);
  assign retire = ex_valid && !mem_stall && (state != HALTED);

  mem_branch_resolve u_br (
    .branch(ex_branch), .zflag(ex_zflag), .opcode(ex_opcode), .jump(ex_jump),
    .cpc(ex_cpc), .imm(ex_imm), .regtarget(ex_regtarget), .jaddr(ex_jaddr),
    .taken(br_taken), .target(br_target)
  );

  assign pc_redirect = retire && br_taken;
  assign pc_target   = pc_redirect ? br_target : '0;

`ifdef MEM_FWD_EN
  logic wb_jal;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= IDLE;
      dmem.dmemREN   <= 1'b0;
      dmem.dmemWEN   <= 1'b0;
      dmem.dmemaddr  <= '0;
      dmem.dmemstore <= '0;
      wb_valid       <= 1'b0;
      wb_regWrite    <= 1'b0;
      wb_memtoReg    <= 1'b0;
      wb_halt        <= 1'b0;
      wb_wsel        <= '0;
      wb_aluout      <= '0;
      wb_dload       <= '0;
      wb_cpc         <= '0;
`ifdef MEM_FWD_EN
      wb_jal         <= 1'b0;
`endif
    end else begin
      wb_valid    <= ld_wb;
      wb_regWrite <= ld_wb && ex_regWrite;
      if (ld_wb) begin
        wb_memtoReg <= ex_memtoReg;
        wb_halt     <= ex_halt;
        wb_wsel     <= ex_wsel;
        wb_aluout   <= ex_aluout;
        wb_cpc      <= ex_cpc;
`ifdef MEM_FWD_EN
        wb_jal      <= (ex_opcode == JAL);
`endif
      end
      case (state)
        IDLE: begin
          if (mem_op) begin
            dmem.dmemaddr  <= ex_aluout;
            dmem.dmemstore <= ex_writeData;
            dmem.dmemREN   <= ex_dren;
            dmem.dmemWEN   <= ex_dwen && !ex_dren;
            state          <= ACCESS;
          end else if (ld_wb && ex_halt) begin
            state <= HALTED;
          end
        end
        ACCESS: begin
          if (dmem.dhit) begin
            if (dmem.dmemREN) wb_dload <= dmem.dmemload;
            dmem.dmemREN <= 1'b0;
            dmem.dmemWEN <= 1'b0;
            state        <= ex_halt ? HALTED : IDLE;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

`ifdef MEM_FWD_EN
  assign fwd_en   = wb_valid && wb_regWrite && (wb_wsel != '0);
  assign fwd_wsel = wb_wsel;
  assign fwd_data = wb_memtoReg ? wb_dload : (wb_jal ? wb_cpc : wb_aluout);
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected MEM/WB entries and redirects; a monitor pops and compares.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic        ex_valid;
  word_t       ex_cpc, ex_aluout, ex_writeData, ex_imm, ex_regtarget;
  logic        ex_regWrite, ex_memtoReg, ex_halt, ex_branch, ex_zflag, ex_dren, ex_dwen;
  logic [1:0]  ex_jump;
  regbits_t    ex_wsel;
  logic [25:0] ex_jaddr;
  opcode_t     ex_opcode;
  logic        mem_stall, pc_redirect;
  word_t       pc_target;
  logic        wb_valid, wb_regWrite, wb_memtoReg, wb_halt;
  regbits_t    wb_wsel;
  word_t       wb_aluout, wb_dload, wb_cpc;
`ifdef MEM_FWD_EN
  logic        fwd_en;
  regbits_t    fwd_wsel;
  word_t       fwd_data;
`endif

  mem_stage_if dif();

  mem_stage dut (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid),
    .ex_cpc(ex_cpc), .ex_aluout(ex_aluout), .ex_writeData(ex_writeData), .ex_imm(ex_imm),
    .ex_regtarget(ex_regtarget), .ex_regWrite(ex_regWrite), .ex_memtoReg(ex_memtoReg),
    .ex_halt(ex_halt), .ex_branch(ex_branch), .ex_zflag(ex_zflag), .ex_dren(ex_dren),
    .ex_dwen(ex_dwen), .ex_jump(ex_jump), .ex_wsel(ex_wsel), .ex_jaddr(ex_jaddr),
    .ex_opcode(ex_opcode), .dmem(dif), .mem_stall(mem_stall), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
    .wb_memtoReg(wb_memtoReg), .wb_halt(wb_halt), .wb_wsel(wb_wsel), .wb_aluout(wb_aluout),
    .wb_dload(wb_dload), .wb_cpc(wb_cpc)
`ifdef MEM_FWD_EN
    , .fwd_en(fwd_en), .fwd_wsel(fwd_wsel), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    opcode_t opcode; logic regWrite, memtoReg, halt, branch, zflag, dren, dwen;
    logic [1:0] jump; regbits_t wsel; logic [25:0] jaddr;
    word_t cpc, aluout, wdata, imm, rtgt, load;
  } op_t;

  typedef struct {
    logic regWrite, memtoReg, halt, jal; regbits_t wsel; word_t aluout, dload, cpc;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  word_t   br_q[$];
  word_t   last_dload = '0;
  int      n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input op_t o);
    ex_opcode = o.opcode; ex_regWrite = o.regWrite; ex_memtoReg = o.memtoReg; ex_halt = o.halt;
    ex_branch = o.branch; ex_zflag = o.zflag; ex_dren = o.dren; ex_dwen = o.dwen;
    ex_jump = o.jump; ex_wsel = o.wsel; ex_jaddr = o.jaddr; ex_cpc = o.cpc;
    ex_aluout = o.aluout; ex_writeData = o.wdata; ex_imm = o.imm; ex_regtarget = o.rtgt;
  endtask

  // Present one op, answer dhit after hit_wait ACCESS cycles, tally request activity
  task automatic run_op(input op_t o, input int hit_wait, input logic taken, input word_t tgt,
                        output int stalls, output int ren_cyc, output int wen_cyc,
                        output word_t addr1, output word_t store1);
    wb_exp_t e;
    bit done;
    e.regWrite = o.regWrite; e.memtoReg = o.memtoReg; e.halt = o.halt;
    e.jal = (o.opcode == JAL); e.wsel = o.wsel; e.aluout = o.aluout; e.cpc = o.cpc;
    e.dload = o.dren ? o.load : last_dload;
    last_dload = e.dload;
    wb_q.push_back(e);
    if (taken) br_q.push_back(tgt);
    stalls = 0; ren_cyc = 0; wen_cyc = 0; addr1 = '0; store1 = '0; done = 0;
    @(posedge CLK); #1;
    drive(o); ex_valid = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      if (c > 0) begin @(posedge CLK); #1; end
      dif.dhit     = (o.dren || o.dwen) && (c == hit_wait + 1);
      dif.dmemload = o.load;
      @(negedge CLK);
      if (dif.dmemREN) ren_cyc++;
      if (dif.dmemWEN) wen_cyc++;
      if (c == 1) begin addr1 = dif.dmemaddr; store1 = dif.dmemstore; end
      if (mem_stall) stalls++; else done = 1;
    end
    if (!done) chk("op_timeout_stall", 32'(mem_stall), 0);
    @(posedge CLK); #1;
    ex_valid = 1'b0; dif.dhit = 1'b0;
    @(negedge CLK);
    if (dif.dmemREN) ren_cyc++;
    if (dif.dmemWEN) wen_cyc++;
  endtask

  wb_exp_t me;
  always @(negedge CLK) begin
    if (nRST) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) chk("wb_valid_unexpected", 32'(wb_valid), 0);
        else begin
          me = wb_q.pop_front();
          chk("wb_regWrite", 32'(wb_regWrite), 32'(me.regWrite));
          chk("wb_memtoReg", 32'(wb_memtoReg), 32'(me.memtoReg));
          chk("wb_halt", 32'(wb_halt), 32'(me.halt));
          chk("wb_wsel", 32'(wb_wsel), 32'(me.wsel));
          chk("wb_aluout", wb_aluout, me.aluout);
          chk("wb_dload", wb_dload, me.dload);
          chk("wb_cpc", wb_cpc, me.cpc);
`ifdef MEM_FWD_EN
          chk("fwd_en", 32'(fwd_en), 32'(me.regWrite && me.wsel != 5'd0));
          chk("fwd_data", fwd_data, me.memtoReg ? me.dload : (me.jal ? me.cpc : me.aluout));
`endif
        end
      end
      if (pc_redirect) begin
        if (br_q.size() == 0) chk("redirect_unexpected", 32'(pc_redirect), 0);
        else chk("pc_target", pc_target, br_q.pop_front());
      end
    end
  end

  initial begin
    op_t o;
    int st, rn, wn;
    word_t a1, s1;
    o = '{default: '0};
    drive(o); ex_valid = 1'b0; dif.dhit = 1'b0; dif.dmemload = '0;

    #12;
    chk("rst_wb_valid", 32'(wb_valid), 0);       chk("rst_wb_regWrite", 32'(wb_regWrite), 0);
    chk("rst_wb_memtoReg", 32'(wb_memtoReg), 0); chk("rst_wb_halt", 32'(wb_halt), 0);
    chk("rst_wb_wsel", 32'(wb_wsel), 0);         chk("rst_wb_aluout", wb_aluout, 0);
    chk("rst_wb_dload", wb_dload, 0);            chk("rst_wb_cpc", wb_cpc, 0);
    chk("rst_ren", 32'(dif.dmemREN), 0);         chk("rst_wen", 32'(dif.dmemWEN), 0);
    chk("rst_addr", dif.dmemaddr, 0);            chk("rst_store", dif.dmemstore, 0);
    @(posedge CLK); #1 nRST = 1'b1;

    o = '{default: '0}; o.regWrite = 1; o.wsel = 5'd3; o.aluout = 32'h55; o.cpc = 32'h8;
    run_op(o, 0, 0, '0, st, rn, wn, a1, s1);
    chk("alu_stall", st, 0);

    o = '{default: '0}; o.opcode = LW; o.regWrite = 1; o.memtoReg = 1; o.dren = 1; o.wsel = 5'd4;
    o.aluout = 32'h100; o.cpc = 32'hC; o.load = 32'hDEADBEEF;
    run_op(o, 3, 0, '0, st, rn, wn, a1, s1);
    chk("lw_stall_cycles", st, 4); chk("lw_addr", a1, 32'h100);

    o = '{default: '0}; o.opcode = SW; o.dwen = 1; o.aluout = 32'h104; o.wdata = 32'h1234;
    o.cpc = 32'h10; o.load = 32'hAAAA5555;
    run_op(o, 0, 0, '0, st, rn, wn, a1, s1);
    chk("sw_stall_cycles", st, 1); chk("sw_wen_cycles", wn, 1); chk("sw_store", s1, 32'h1234);

    o = '{default: '0}; o.opcode = LW; o.regWrite = 1; o.memtoReg = 1; o.dren = 1; o.dwen = 1;
    o.wsel = 5'd5; o.aluout = 32'h108; o.cpc = 32'h14; o.load = 32'h0BADF00D;
    run_op(o, 0, 0, '0, st, rn, wn, a1, s1);
    chk("rw_wen_cycles", wn, 0); chk("rw_ren_cycles", rn, 1);

    o = '{default: '0}; o.opcode = BEQ; o.branch = 1; o.zflag = 1; o.cpc = 32'h40; o.imm = 32'hFFFFFFFE;
    run_op(o, 0, 1, 32'h38, st, rn, wn, a1, s1);
    o.opcode = BNE;
    run_op(o, 0, 0, '0, st, rn, wn, a1, s1);

    o = '{default: '0}; o.opcode = J; o.jump = JMP_J; o.cpc = 32'h80000010; o.jaddr = 26'h10;
    run_op(o, 0, 1, 32'h80000040, st, rn, wn, a1, s1);
    o = '{default: '0}; o.opcode = JAL; o.jump = JMP_J; o.regWrite = 1; o.wsel = 5'd31;
    o.cpc = 32'h1004; o.aluout = 32'h99; o.jaddr = 26'h20;
    run_op(o, 0, 1, 32'h80, st, rn, wn, a1, s1);
    o = '{default: '0}; o.jump = JMP_JR; o.rtgt = 32'h200; o.cpc = 32'h1008;
    run_op(o, 0, 1, 32'h200, st, rn, wn, a1, s1);
    o = '{default: '0}; o.jump = 2'b11; o.rtgt = 32'h300; o.cpc = 32'h100C;
    run_op(o, 0, 0, '0, st, rn, wn, a1, s1);

    // reset while a load is outstanding
    @(posedge CLK); #1;
    o = '{default: '0}; o.opcode = LW; o.dren = 1; o.aluout = 32'h200;
    drive(o); ex_valid = 1'b1; dif.dhit = 1'b0;
    @(negedge CLK); chk("rst_entry_stall", 32'(mem_stall), 1);
    @(negedge CLK); chk("rst_pre_ren", 32'(dif.dmemREN), 1);
    #2 nRST = 1'b0;
    #1;
    chk("rst_async_ren", 32'(dif.dmemREN), 0); chk("rst_async_addr", dif.dmemaddr, 0);
    chk("rst_async_wb_cpc", wb_cpc, 0);        chk("rst_async_wb_dload", wb_dload, 0);
    ex_valid = 1'b0; last_dload = '0;
    @(posedge CLK); @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    chk("rst_idle_stall", 32'(mem_stall), 0); chk("rst_idle_ren", 32'(dif.dmemREN), 0);

    o = '{default: '0}; o.regWrite = 1; o.wsel = 5'd7; o.aluout = 32'h77; o.cpc = 32'h4;
    run_op(o, 0, 0, '0, st, rn, wn, a1, s1);
    chk("post_rst_alu_stall", st, 0);

    o = '{default: '0}; o.halt = 1; o.cpc = 32'h20; o.aluout = 32'h5;
    run_op(o, 0, 0, '0, st, rn, wn, a1, s1);

    @(posedge CLK); #1;
    o = '{default: '0}; o.opcode = LW; o.dren = 1; o.regWrite = 1; o.wsel = 5'd8; o.aluout = 32'h300;
    drive(o); ex_valid = 1'b1; dif.dhit = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("halt_ren", 32'(dif.dmemREN), 0); chk("halt_stall", 32'(mem_stall), 0);
      chk("halt_hold", 32'(wb_halt), 1);
`ifdef MEM_FWD_EN
      chk("halt_fwd_en", 32'(fwd_en), 0);
`endif
    end
    @(posedge CLK); #1;
    o = '{default: '0}; o.jump = JMP_JR; o.rtgt = 32'h400;
    drive(o); dif.dhit = 1'b0;
    @(negedge CLK); chk("halt_no_redirect", 32'(pc_redirect), 0);
    @(posedge CLK); #1 ex_valid = 1'b0;
    @(negedge CLK);

    chk("wb_queue_drained", wb_q.size(), 0);
    chk("br_queue_drained", br_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
